// File: rtl/native_axil_master.sv
// -----------------------------------------------------------------------------
// native_axil_master
//   Bridges a simple native request/response port to an AXI4-Lite master.
//   The write channel (AW/W/B) and read channel (AR/R) are independent FSMs
//   and may both be in flight at once. Response codes pass through unchanged.
//
// Parameters
//   DATA_W       data width (32 or 64); STRB_W = DATA_W/8
//   ADDR_W       address width
//   TIMEOUT_CYC  slave-wait limit in cycles (timeout build only)
//
// Optional feature
//   NATIVE_AXIL_TIMEOUT_EN  when defined, each channel gives up after
//                           TIMEOUT_CYC cycles in a waiting state, completes
//                           with resp 2'b11 (zero read data) and sets the
//                           sticky tmo_o flag. Undefined: channels wait
//                           forever and tmo_o is tied 0.
//
// Ports
//   clk_i, rst_n_i                       clock, async active-low reset
//   wr_valid_i/wr_ready_o                native write command handshake
//   wr_addr_i, wr_data_i, wr_strb_i      write command payload
//   wr_done_o, wr_resp_o                 one-cycle completion pulse + BRESP
//   rd_req_i/rd_req_ready_o, rd_addr_i   native read command
//   rd_valid_o/rd_ready_i                read result handshake
//   rd_data_o, rd_resp_o                 read data + RRESP
//   tmo_o                                sticky timeout flag
//   m_axi_*                              AXI4-Lite master channels
// -----------------------------------------------------------------------------
module native_axil_master #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic [DATA_W/8-1:0]   wr_strb_i,
    output logic                  wr_done_o,
    output logic [1:0]            wr_resp_o,
    input  logic                  rd_req_i,
    output logic                  rd_req_ready_o,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic [1:0]            rd_resp_o,
    output logic                  tmo_o,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {W_IDLE, W_AW, W_B} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_AR, R_R, R_HOLD} r_state_t;

    w_state_t            r_w_state, w_w_state_nxt;
    r_state_t            r_r_state, w_r_state_nxt;

    logic [ADDR_W-1:0]   r_awaddr, w_awaddr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic [STRB_W-1:0]   r_wstrb, w_wstrb_nxt;
    logic                r_awvalid, w_awvalid_nxt;
    logic                r_wvalid, w_wvalid_nxt;
    logic                r_bready, w_bready_nxt;
    logic                r_aw_done, w_aw_done_nxt;
    logic                r_w_done, w_w_done_nxt;
    logic                r_wr_done, w_wr_done_nxt;
    logic [1:0]          r_wr_resp, w_wr_resp_nxt;

    logic [ADDR_W-1:0]   r_araddr, w_araddr_nxt;
    logic                r_arvalid, w_arvalid_nxt;
    logic                r_rready, w_rready_nxt;
    logic                r_rd_valid, w_rd_valid_nxt;
    logic [DATA_W-1:0]   r_rd_data, w_rd_data_nxt;
    logic [1:0]          r_rd_resp, w_rd_resp_nxt;

    logic                w_aw_hs, w_w_hs;

    assign w_aw_hs = r_awvalid & m_axi_awready;
    assign w_w_hs  = r_wvalid & m_axi_wready;

`ifdef NATIVE_AXIL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    r_w_cnt, r_r_cnt;
    logic                w_w_tmo_hit, w_r_tmo_hit;
    logic                w_wr_tmo, w_rd_tmo;
    logic                r_tmo;

    assign w_w_tmo_hit = (r_w_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_r_tmo_hit = (r_r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign tmo_o       = r_tmo;
`else
    logic                w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYC == 0);
    assign tmo_o        = 1'b0;
`endif

    assign wr_ready_o     = (r_w_state == W_IDLE);
    assign rd_req_ready_o = (r_r_state == R_IDLE);

    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;
    assign wr_done_o     = r_wr_done;
    assign wr_resp_o     = r_wr_resp;
    assign rd_valid_o    = r_rd_valid;
    assign rd_data_o     = r_rd_data;
    assign rd_resp_o     = r_rd_resp;

    // Write FSM: next state and next register values
    always_comb begin
        w_w_state_nxt = r_w_state;
        w_awaddr_nxt  = r_awaddr;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_wr_done_nxt = 1'b0;
        w_wr_resp_nxt = r_wr_resp;
`ifdef NATIVE_AXIL_TIMEOUT_EN
        w_wr_tmo      = 1'b0;
`endif
        case (r_w_state)
            W_IDLE: begin
                if (wr_valid_i) begin
                    w_awaddr_nxt  = wr_addr_i;
                    w_wdata_nxt   = wr_data_i;
                    w_wstrb_nxt   = wr_strb_i;
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_w_state_nxt = W_AW;
                end
            end
            W_AW: begin
                if (w_aw_hs) begin
                    w_awvalid_nxt = 1'b0;
                    w_aw_done_nxt = 1'b1;
                end
                if (w_w_hs) begin
                    w_wvalid_nxt = 1'b0;
                    w_w_done_nxt = 1'b1;
                end
                // Count handshakes landing this cycle so AW and W may finish together
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_bready_nxt  = 1'b1;
                    w_w_state_nxt = W_B;
                end
`ifdef NATIVE_AXIL_TIMEOUT_EN
                else if (w_w_tmo_hit) begin
                    w_awvalid_nxt = 1'b0;
                    w_wvalid_nxt  = 1'b0;
                    w_wr_resp_nxt = 2'b11;
                    w_wr_done_nxt = 1'b1;
                    w_wr_tmo      = 1'b1;
                    w_w_state_nxt = W_IDLE;
                end
`endif
            end
            W_B: begin
                if (m_axi_bvalid) begin
                    w_bready_nxt  = 1'b0;
                    w_wr_resp_nxt = m_axi_bresp;
                    w_wr_done_nxt = 1'b1;
                    w_w_state_nxt = W_IDLE;
                end
`ifdef NATIVE_AXIL_TIMEOUT_EN
                else if (w_w_tmo_hit) begin
                    w_bready_nxt  = 1'b0;
                    w_wr_resp_nxt = 2'b11;
                    w_wr_done_nxt = 1'b1;
                    w_wr_tmo      = 1'b1;
                    w_w_state_nxt = W_IDLE;
                end
`endif
            end
            default: w_w_state_nxt = W_IDLE;
        endcase
    end

    // Read FSM: next state and next register values
    always_comb begin
        w_r_state_nxt  = r_r_state;
        w_araddr_nxt   = r_araddr;
        w_arvalid_nxt  = r_arvalid;
        w_rready_nxt   = r_rready;
        w_rd_valid_nxt = r_rd_valid;
        w_rd_data_nxt  = r_rd_data;
        w_rd_resp_nxt  = r_rd_resp;
`ifdef NATIVE_AXIL_TIMEOUT_EN
        w_rd_tmo       = 1'b0;
`endif
        case (r_r_state)
            R_IDLE: begin
                if (rd_req_i) begin
                    w_araddr_nxt  = rd_addr_i;
                    w_arvalid_nxt = 1'b1;
                    w_r_state_nxt = R_AR;
                end
            end
            R_AR: begin
                if (m_axi_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_r_state_nxt = R_R;
                end
`ifdef NATIVE_AXIL_TIMEOUT_EN
                else if (w_r_tmo_hit) begin
                    w_arvalid_nxt  = 1'b0;
                    w_rd_valid_nxt = 1'b1;
                    w_rd_data_nxt  = '0;
                    w_rd_resp_nxt  = 2'b11;
                    w_rd_tmo       = 1'b1;
                    w_r_state_nxt  = R_HOLD;
                end
`endif
            end
            R_R: begin
                if (m_axi_rvalid) begin
                    w_rready_nxt   = 1'b0;
                    w_rd_valid_nxt = 1'b1;
                    w_rd_data_nxt  = m_axi_rdata;
                    w_rd_resp_nxt  = m_axi_rresp;
                    w_r_state_nxt  = R_HOLD;
                end
`ifdef NATIVE_AXIL_TIMEOUT_EN
                else if (w_r_tmo_hit) begin
                    w_rready_nxt   = 1'b0;
                    w_rd_valid_nxt = 1'b1;
                    w_rd_data_nxt  = '0;
                    w_rd_resp_nxt  = 2'b11;
                    w_rd_tmo       = 1'b1;
                    w_r_state_nxt  = R_HOLD;
                end
`endif
            end
            R_HOLD: begin
                if (rd_ready_i) begin
                    w_rd_valid_nxt = 1'b0;
                    w_r_state_nxt  = R_IDLE;
                end
            end
            default: w_r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_w_state  <= W_IDLE;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_wr_done  <= 1'b0;
            r_wr_resp  <= 2'b00;
            r_r_state  <= R_IDLE;
            r_araddr   <= '0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_resp  <= 2'b00;
        end else begin
            r_w_state  <= w_w_state_nxt;
            r_awaddr   <= w_awaddr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_wstrb    <= w_wstrb_nxt;
            r_awvalid  <= w_awvalid_nxt;
            r_wvalid   <= w_wvalid_nxt;
            r_bready   <= w_bready_nxt;
            r_aw_done  <= w_aw_done_nxt;
            r_w_done   <= w_w_done_nxt;
            r_wr_done  <= w_wr_done_nxt;
            r_wr_resp  <= w_wr_resp_nxt;
            r_r_state  <= w_r_state_nxt;
            r_araddr   <= w_araddr_nxt;
            r_arvalid  <= w_arvalid_nxt;
            r_rready   <= w_rready_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_resp  <= w_rd_resp_nxt;
        end
    end

`ifdef NATIVE_AXIL_TIMEOUT_EN
    // Wait counters restart on every state change and idle in IDLE/R_HOLD
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_w_cnt <= '0;
            r_r_cnt <= '0;
            r_tmo   <= 1'b0;
        end else begin
            if (r_w_state == W_IDLE || w_w_state_nxt != r_w_state)
                r_w_cnt <= '0;
            else
                r_w_cnt <= r_w_cnt + 1'b1;
            if (r_r_state == R_IDLE || r_r_state == R_HOLD || w_r_state_nxt != r_r_state)
                r_r_cnt <= '0;
            else
                r_r_cnt <= r_r_cnt + 1'b1;
            r_tmo <= r_tmo | w_wr_tmo | w_rd_tmo;
        end
    end
`endif

endmodule

// File: doc/native_axil_master.md
# native_axil_master

Parametrised native-to-AXI4-Lite master bridge. It gives the UART command path and other internal controllers a simple request/response port, and drives the AXI4-Lite register slaves of the HDMI driver. Write and read channels run independently and may be in flight at the same time. Writes carry byte strobes and report the full BRESP; reads are fully implemented with RRESP.

## Interface
Parameters:
- DATA_W, 32: data width; must be 32 or 64.
- ADDR_W, 8: address width.
- TIMEOUT_CYC, 255: slave-wait limit in cycles; used only with the timeout macro.

Derived: STRB_W = DATA_W/8.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- wr_valid_i  in  1  write command valid.
- wr_ready_o  out  1  write command accepted when both high.
- wr_addr_i  in  ADDR_W  write address.
- wr_data_i  in  DATA_W  write data.
- wr_strb_i  in  STRB_W  byte enables.
- wr_done_o  out  1  one-cycle completion pulse.
- wr_resp_o  out  2  response code; valid with wr_done_o.
- rd_req_i  in  1  read command valid.
- rd_req_ready_o  out  1  read command accepted when both high.
- rd_addr_i  in  ADDR_W  read address.
- rd_valid_o  out  1  read result valid.
- rd_ready_i  in  1  read result consumed.
- rd_data_o  out  DATA_W  read data.
- rd_resp_o  out  2  read response code.
- tmo_o  out  1  sticky timeout flag.
- m_axi_aw*: awaddr, awvalid, awready.
- m_axi_w*: wdata, wstrb, wvalid, wready.
- m_axi_b*: bresp, bvalid, bready.
- m_axi_ar*: araddr, arvalid, arready.
- m_axi_r*: rdata, rresp, rvalid, rready.
- All AXI widths follow ADDR_W, DATA_W, STRB_W, 2-bit resp.

## Operation
- Reset (async) values:
  - All AXI valid and ready outputs 0.
  - wr_done_o, rd_valid_o, tmo_o 0.
  - wr_resp_o, rd_resp_o, rd_data_o 0; AXI address/data/strobe outputs 0.
  - Both FSMs go to IDLE.
- wr_ready_o is high iff the write FSM is in W_IDLE. rd_req_ready_o is high iff the read FSM is in R_IDLE.
- Write FSM:
  - W_IDLE: on wr_valid_i, register addr/data/strb, set awvalid=wvalid=1, clear aw_done/w_done, go to W_AW.
  - W_AW: each AW or W handshake drops its valid and sets its done flag; handshakes may land in the same or different cycles. When both flags are set (counting this cycle's handshakes), set bready=1 and go to W_B.
  - W_B: on bvalid, bready=0, wr_resp_o=bresp, pulse wr_done_o next cycle, go to W_IDLE.
- Read FSM:
  - R_IDLE: on rd_req_i, register address, arvalid=1, go to R_AR.
  - R_AR: on arready, arvalid=0, rready=1, go to R_R.
  - R_R: on rvalid, rready=0, capture rdata/rresp, rd_valid_o=1, go to R_HOLD.
  - R_HOLD: rd_data_o and rd_resp_o held stable; on rd_ready_i, rd_valid_o=0, go to R_IDLE.
- Response codes pass through unmodified; nonzero means error.
- A write and a read may be accepted in the same cycle. No ordering between the channels is enforced.
- Reset asserted mid-transaction abandons it immediately; no completion is reported.

## Timing
- All outputs registered, except wr_ready_o and rd_req_ready_o (decoded from state).
- AXI valid rises the cycle after native acceptance, and is held until its handshake.
- Minimum write latency, accept at cycle N:
  - AW/W handshake at N+1.
  - bready high at N+2; B handshake at N+2.
  - wr_done_o at N+3; wr_ready_o high at N+3.
- Minimum read latency, accept at cycle N:
  - AR handshake at N+1.
  - R handshake at N+2.
  - rd_valid_o at N+3.
  - If rd_ready_i is high at N+3, rd_req_ready_o is high at N+4.
- Backpressure on any AXI ready stretches latency cycle for cycle.

## Configuration
- NATIVE_AXIL_TIMEOUT_EN defined:
  - A per-channel counter runs in every non-IDLE, non-R_HOLD state, reset on every state change.
  - On reaching TIMEOUT_CYC, the channel drops its valid/ready outputs and completes with resp 2'b11, with zero data for reads.
  - tmo_o is set and stays high until reset.
- Macro undefined: no counters, channels wait indefinitely, tmo_o tied 0, TIMEOUT_CYC unused.

## Test plan
- Zero-wait slave, write addr 0x10, data 0xDEADBEEF, strb 0xF -> awaddr=0x10, wstrb=0xF, wr_done_o at N+3, wr_resp_o=0.
- awready delayed 4 cycles, wready immediate, strb 0x3 -> wvalid drops at N+2, awvalid drops at N+5, bready only after both handshakes, single wr_done_o.
- Read addr 0x04, slave returns 0x12345678 with rresp 2'b10; rd_ready_i held low 3 cycles -> rd_valid_o/data/resp stable 3+ cycles, then released; rd_req_ready_o high the cycle after consumption.
- Write and read accepted the same cycle with interleaved slave responses -> both complete with correct data/resp and no cross-channel corruption.
- rst_n_i pulsed low while awvalid=1 -> awvalid 0 asynchronously; wr_ready_o=1 and no wr_done_o after release.
- With NATIVE_AXIL_TIMEOUT_EN, TIMEOUT_CYC=16, bvalid never asserted -> 16 cycles into W_B bready drops, wr_done_o with wr_resp_o=2'b11, tmo_o=1 until reset.
